// File: rtl/uart_rx_core_if.sv
// rtl/uart_rx_core_if.sv - UART receiver line/control inputs and byte/status outputs
interface uart_rx_core_if;
  logic       rx_enbl;
  logic       rx;
  logic       parity_en;
  logic       parity_odd;
  logic [7:0] dout;
  logic       flag;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx_enbl, rx, parity_en, parity_odd,
    input  dout, flag, parity_err, frame_err, busy
  );

  modport slave (
    input  rx_enbl, rx, parity_en, parity_odd,
    output dout, flag, parity_err, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 16x oversampling UART receiver, 8 data bits LSB first, optional parity, 1 stop
module uart_rx_core #(
  parameter int DIV         = 27,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           areset_n,
  uart_rx_core_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HI
  } state_t;

  typedef enum logic [1:0] {
    P_NONE, P_OK, P_PERR, P_FERR
  } pend_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rx_s;
  logic                   w_tick;
  logic                   w_mid;

  state_t      r_state;
  pend_t       r_pend;
  logic [15:0] r_pre;
  logic [3:0]  r_os;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shreg;
  logic        r_xor;
  logic        r_par_en;
  logic        r_par_odd;
  logic        r_perr;
  logic [7:0]  r_dout;
  logic        r_flag;
  logic        r_parity_err;
  logic        r_frame_err;
  logic        r_busy;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.rx};
    end
  end

  assign w_rx_s = r_sync[SYNC_STAGES-1];
  assign w_tick = (r_pre == 16'(DIV - 1));
  assign w_mid  = w_tick && (r_os == 4'd7);

  // Stop-bit verdicts are parked in r_pend and published one clock later.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state      <= S_IDLE;
      r_pend       <= P_NONE;
      r_pre        <= '0;
      r_os         <= '0;
      r_bit_cnt    <= '0;
      r_shreg      <= '0;
      r_xor        <= 1'b0;
      r_par_en     <= 1'b0;
      r_par_odd    <= 1'b0;
      r_perr       <= 1'b0;
      r_dout       <= 8'h00;
      r_flag       <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_flag       <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_pend       <= P_NONE;
      case (r_pend)
        P_OK: begin
          r_flag <= 1'b1;
          r_dout <= r_shreg;
        end
        P_PERR:  r_parity_err <= 1'b1;
        P_FERR:  r_frame_err  <= 1'b1;
        default: ;
      endcase

      if (r_state != S_IDLE) begin
        r_pre <= w_tick ? 16'd0 : r_pre + 16'd1;
        if (w_tick) r_os <= r_os + 4'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.rx_enbl && !w_rx_s) begin
            r_state   <= S_START;
            r_busy    <= 1'b1;
            r_pre     <= '0;
            r_os      <= '0;
            r_par_en  <= bus.parity_en;
            r_par_odd <= bus.parity_odd;
            r_perr    <= 1'b0;
          end
        end
        S_START: begin
          if (w_mid) begin
            if (!w_rx_s) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
              r_xor     <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (w_mid) begin
            r_shreg   <= {w_rx_s, r_shreg[7:1]};
            r_xor     <= r_xor ^ w_rx_s;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= r_par_en ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (w_mid) begin
            r_perr  <= ((r_xor ^ w_rx_s) != r_par_odd);
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_mid) begin
            if (!w_rx_s) begin
              r_pend  <= P_FERR;
              r_state <= S_WAIT_HI;
            end else begin
              r_pend  <= r_perr ? P_PERR : P_OK;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        S_WAIT_HI: begin
          if (w_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout       = r_dout;
  assign bus.flag       = r_flag;
  assign bus.parity_err = r_parity_err;
  assign bus.frame_err  = r_frame_err;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed-vector bench for uart_rx_core at DIV=1
module tb_uart_rx_core;

  logic clk;
  logic areset_n;
  uart_rx_core_if bus ();

  uart_rx_core #(.DIV(1), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_flag = 0;
  int n_perr = 0;
  int n_ferr = 0;
  int busy_seen = 0;
  int t_fall = 0;
  logic [7:0] flag_dout [0:63];
  int         flag_t    [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.flag) begin
      if (n_flag < 64) begin
        flag_dout[n_flag] = bus.dout;
        flag_t[n_flag]    = cyc;
      end
      n_flag++;
    end
    if (bus.parity_err) n_perr++;
    if (bus.frame_err)  n_ferr++;
    if (bus.busy)       busy_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    bus.rx = v;
    wait_clk(16);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic pen, input logic pbit, input logic stopb);
    t_fall = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (pen) drive_bit(pbit);
    drive_bit(stopb);
    bus.rx = 1'b1;
  endtask

  int f0, p0, e0, b0;

  initial begin
    areset_n       = 1'b0;
    bus.rx         = 1'b1;
    bus.rx_enbl    = 1'b1;
    bus.parity_en  = 1'b0;
    bus.parity_odd = 1'b0;
    wait_clk(3);
    check("rst_dout", {24'd0, bus.dout}, 32'h00);
    check("rst_flag", {31'd0, bus.flag}, 32'd0);
    check("rst_perr", {31'd0, bus.parity_err}, 32'd0);
    check("rst_ferr", {31'd0, bus.frame_err}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    areset_n = 1'b1;
    wait_clk(5);

    // 0xA5, no parity
    f0 = n_flag; p0 = n_perr; e0 = n_ferr;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    wait_clk(20);
    check("a5_nflag", n_flag - f0, 1);
    check("a5_dout", {24'd0, flag_dout[f0]}, 32'hA5);
    check("a5_latency", flag_t[f0] - t_fall, 156);
    check("a5_noerr", (n_perr - p0) + (n_ferr - e0), 0);
    check("a5_idle", {31'd0, bus.busy}, 32'd0);

    // back-to-back 0x00, 0xFF
    f0 = n_flag;
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    wait_clk(20);
    check("b2b_nflag", n_flag - f0, 2);
    check("b2b_dout0", {24'd0, flag_dout[f0]}, 32'h00);
    check("b2b_dout1", {24'd0, flag_dout[f0+1]}, 32'hFF);
    check("b2b_spacing", flag_t[f0+1] - flag_t[f0], 160);

    // even parity, 0x07 with wrong then right parity bit
    bus.parity_en = 1'b1;
    bus.parity_odd = 1'b0;
    f0 = n_flag; p0 = n_perr;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    wait_clk(20);
    check("par_bad_perr", n_perr - p0, 1);
    check("par_bad_noflag", n_flag - f0, 0);
    check("par_bad_dout", {24'd0, bus.dout}, 32'hFF);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    wait_clk(20);
    check("par_ok_nflag", n_flag - f0, 1);
    check("par_ok_dout", {24'd0, flag_dout[f0]}, 32'h07);
    check("par_ok_latency", flag_t[f0] - t_fall, 172);
    check("par_ok_perr", n_perr - p0, 1);
    bus.parity_en = 1'b0;

    // framing error followed by a long break
    f0 = n_flag; p0 = n_perr; e0 = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    bus.rx = 1'b0;
    wait_clk(400);
    check("brk_ferr", n_ferr - e0, 1);
    check("brk_busy", {31'd0, bus.busy}, 32'd1);
    bus.rx = 1'b1;
    wait_clk(6);
    check("brk_idle", {31'd0, bus.busy}, 32'd0);
    check("brk_noflag", (n_flag - f0) + (n_perr - p0), 0);
    check("brk_dout", {24'd0, bus.dout}, 32'h07);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    wait_clk(20);
    check("post_brk_dout", {24'd0, bus.dout}, 32'h55);
    check("post_brk_nflag", n_flag - f0, 1);
    check("post_brk_ferr", n_ferr - e0, 1);

    // short glitch in IDLE
    f0 = n_flag; p0 = n_perr; e0 = n_ferr;
    bus.rx = 1'b0;
    wait_clk(4);
    bus.rx = 1'b1;
    wait_clk(30);
    check("glitch_nopulse", (n_flag - f0) + (n_perr - p0) + (n_ferr - e0), 0);
    check("glitch_idle", {31'd0, bus.busy}, 32'd0);
    check("glitch_dout", {24'd0, bus.dout}, 32'h55);

    // receiver disabled
    bus.rx_enbl = 1'b0;
    b0 = busy_seen;
    send_frame(8'h96, 1'b0, 1'b0, 1'b1);
    wait_clk(20);
    check("dis_busy", busy_seen - b0, 0);
    check("dis_nopulse", (n_flag - f0) + (n_perr - p0) + (n_ferr - e0), 0);
    bus.rx_enbl = 1'b1;

    // reset during data bit 4
    f0 = n_flag;
    bus.rx = 1'b0;
    wait_clk(16);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    bus.rx = 1'b0;
    wait_clk(8);
    areset_n = 1'b0;
    #2;
    check("mid_rst_dout", {24'd0, bus.dout}, 32'h00);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_flag", {31'd0, bus.flag}, 32'd0);
    bus.rx = 1'b1;
    wait_clk(3);
    areset_n = 1'b1;
    wait_clk(3);
    check("mid_rst_noflag", n_flag - f0, 0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    wait_clk(20);
    check("rst_rx_nflag", n_flag - f0, 1);
    check("rst_rx_dout", {24'd0, bus.dout}, 32'h81);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
